// File: rtl/alu_muldiv_controller_if.sv
// Request/response bundle between the instruction decoder and the multiply/divide controller.
// The master drives the decoded fields and operands; the slave returns opcode, status and result.
interface alu_muldiv_controller_if #(
  parameter int XLEN = 32
);
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      Operation;
  logic            md_op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] md_result;
  logic            busy;

  modport master (
    output ALUOp, Funct7, Funct3, SrcA, SrcB, in_valid, out_ready,
    input  in_ready, Operation, md_op, out_valid, md_result, busy
  );

  modport slave (
    input  ALUOp, Funct7, Funct3, SrcA, SrcB, in_valid, out_ready,
    output in_ready, Operation, md_op, out_valid, md_result, busy
  );
endinterface

// File: rtl/alu_muldiv_controller.sv
// ALU control decoder plus an iterative multiply/divide unit (shift-add multiply,
// restoring divide, one bit per cycle) behind a valid/ready handshake.
module alu_muldiv_controller #(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                reset,
  alu_muldiv_controller_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] res_q;

  // captured request
  logic [2:0]      f3_q;
  logic            is_div_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic            div0_q;
  logic            ovf_q;
  logic [XLEN-1:0] a_raw_q;
  logic [XLEN-1:0] ma_q;
  logic [XLEN-1:0] mb_q;
  logic [W2-1:0]   prod_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;

  logic            md_op_w;
  logic [3:0]      op_w;
  logic            accept;
  logic            last;

  function automatic logic [W2-1:0] neg_wide(input logic [W2-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_comb begin
    md_op_w = (bus.ALUOp == 2'b10) && (bus.Funct7 == 7'b0000001);
    op_w    = 4'b0010;
    if (bus.ALUOp == 2'b00) begin
      op_w = 4'b0010;
    end else if (bus.ALUOp == 2'b01) begin
      op_w = 4'b0110;
    end else if (md_op_w) begin
      op_w = 4'b0010;
    end else begin
      case (bus.Funct3)
        3'b000: op_w = (bus.ALUOp == 2'b10 && bus.Funct7 == 7'b0100000) ? 4'b0110 : 4'b0010;
        3'b001: op_w = 4'b0011;
        3'b010: op_w = 4'b0111;
        3'b011: op_w = 4'b1111;
        3'b100: op_w = 4'b1100;
        3'b101: op_w = (bus.Funct7 == 7'b0100000) ? 4'b1010 : 4'b1000;
        3'b110: op_w = 4'b0001;
        default: op_w = 4'b0000;
      endcase
    end
  end

  assign bus.md_op     = md_op_w;
  assign bus.Operation = op_w;

  assign accept = (state_q == IDLE) && bus.in_valid && md_op_w && !reset;
  assign last   = (state_q == EXEC) && (cnt_q == CW'(XLEN - 1));

  // Operand conditioning: which sources are signed depends on funct3.
  logic                   a_sgn_w, b_sgn_w, a_neg_w, b_neg_w;
  logic signed [XLEN-1:0] sa_w, sb_w;
  logic [XLEN-1:0]        ma_w, mb_w;

  always_comb begin
    sa_w    = bus.SrcA;
    sb_w    = bus.SrcB;
    a_sgn_w = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
              (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    b_sgn_w = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    a_neg_w = a_sgn_w && (sa_w < 0);
    b_neg_w = b_sgn_w && (sb_w < 0);
    ma_w    = neg_word(bus.SrcA, a_neg_w);
    mb_w    = neg_word(bus.SrcB, b_neg_w);
  end

  // One iteration of each algorithm, plus the sign-corrected result of the final one.
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [W2-1:0]   prod_nxt, prod_fix;
  logic [XLEN-1:0] rem_nxt, quo_nxt, q_fix, r_fix, mul_res, div_res, final_res;

  always_comb begin
    mul_sum  = {1'b0, prod_q[W2-1:XLEN]} + (prod_q[0] ? {1'b0, ma_q} : {(XLEN+1){1'b0}});
    prod_nxt = {mul_sum, prod_q[XLEN-1:1]};

    div_sh   = {rem_q, quo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mb_q};
    if (!div_diff[XLEN]) begin
      rem_nxt = div_diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = div_sh[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end

    prod_fix = neg_wide(prod_nxt, a_neg_q ^ b_neg_q);
    mul_res  = (f3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[W2-1:XLEN];

    q_fix = neg_word(quo_nxt, a_neg_q ^ b_neg_q);
    r_fix = neg_word(rem_nxt, a_neg_q);
    if (div0_q) begin
      q_fix = {XLEN{1'b1}};
      r_fix = a_raw_q;
    end else if (ovf_q) begin
      q_fix = a_raw_q;
      r_fix = '0;
    end
    div_res   = f3_q[1] ? r_fix : q_fix;
    final_res = is_div_q ? div_res : mul_res;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid && md_op_w) state_nxt = EXEC;
      EXEC:    if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
  end

  assign bus.md_result = res_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      if (accept)                 cnt_q <= '0;
      else if (state_q == EXEC)   cnt_q <= cnt_q + CW'(1);
      if (last)                   res_q <= final_res;
    end
  end

  // Datapath registers: no reset needed, everything is reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q     <= bus.Funct3;
      is_div_q <= bus.Funct3[2];
      a_neg_q  <= a_neg_w;
      b_neg_q  <= b_neg_w;
      a_raw_q  <= bus.SrcA;
      div0_q   <= bus.Funct3[2] && (bus.SrcB == '0);
      ovf_q    <= (bus.Funct3 == 3'b100 || bus.Funct3 == 3'b110) &&
                  (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcB == {XLEN{1'b1}});
      ma_q     <= ma_w;
      mb_q     <= mb_w;
      prod_q   <= {{XLEN{1'b0}}, mb_w};
      rem_q    <= '0;
      quo_q    <= ma_w;
    end else if (state_q == EXEC) begin
      prod_q <= prod_nxt;
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
    end
  end

endmodule

// File: doc/alu_muldiv_controller.md
ALU_MULDIV_CONTROLLER -- requirements
Module: alu_muldiv_controller

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two >= 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ALUOp  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-005 Funct7  input  7  instruction funct7 field.
REQ-006 Funct3  input  3  instruction funct3 field.
REQ-007 SrcA, SrcB  input  XLEN each  operands for multiply/divide.
REQ-008 in_valid  input  1  operands and fields valid this cycle.
REQ-009 in_ready  output  1  block can accept a multiply/divide request.
REQ-010 Operation  output  4  combinational base-ALU opcode.
REQ-011 md_op  output  1  combinational; decoded fields select multiply/divide.
REQ-012 out_valid  output  1  md_result valid.
REQ-013 out_ready  input  1  consumer accepts md_result.
REQ-014 md_result  output  XLEN  multiply/divide result.
REQ-015 busy  output  1  high whenever state != IDLE.

Function
REQ-016 md_op SHALL be 1 iff ALUOp=10 and Funct7=0000001.
REQ-017 Operation SHALL be: ALUOp 00 -> 0010; 01 -> 0110; md_op -> 0010; otherwise by Funct3: 000 ADD 0010 (SUB 0110 only if ALUOp=10 and Funct7=0100000), 001 SLL 0011, 010 SLT 0111, 011 SLTU 1111, 100 XOR 1100, 101 SRL 1000 (SRA 1010 if Funct7=0100000, both ALUOp 10 and 11), 110 OR 0001, 111 AND 0000.
REQ-018 Request accepted on rising edge with in_valid & in_ready & md_op; non-md_op inputs SHALL never start the FSM.
REQ-019 FSM states IDLE, EXEC, DONE; IDLE->EXEC on acceptance; EXEC->DONE after exactly XLEN iterations; DONE->IDLE on edge with out_ready=1; DONE holds otherwise.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; md_result SHALL be stable throughout DONE.
REQ-021 Latency: out_valid SHALL rise in the cycle after the XLEN-th rising edge following the accepting edge; a new request SHALL be acceptable no earlier than the cycle after the edge leaving DONE.
REQ-022 Operands and Funct3 SHALL be captured at acceptance; later input changes SHALL not affect the result.
REQ-023 Funct3 000 MUL low XLEN bits; 001 MULH signed x signed high; 010 MULHSU signed x unsigned high; 011 MULHU unsigned high; 100 DIV signed; 101 DIVU; 110 REM signed; 111 REMU.
REQ-024 Multiply SHALL be iterative shift-add (one bit per cycle) on magnitudes, 2*XLEN-bit product, sign correction applied on entry to DONE.
REQ-025 Divide SHALL be iterative restoring (one quotient bit per cycle) on magnitudes; quotient sign = sign(A) xor sign(B), remainder sign = sign(A).
REQ-026 Divide by zero: quotient SHALL be all ones, remainder SHALL equal SrcA; same latency.
REQ-027 Signed overflow (SrcA = -2^(XLEN-1), SrcB = -1): DIV SHALL return SrcA, REM SHALL return 0; same latency.
REQ-028 Iteration counter SHALL be clog2(XLEN)+1 bits and SHALL not wrap within an operation.

Reset
REQ-029 reset=1 at a rising edge SHALL force state IDLE, counter 0, md_result 0, out_valid 0, busy 0, in_ready 1, from any state including mid-EXEC; the in-flight operation SHALL be discarded.
REQ-030 Acceptance SHALL not occur on an edge where reset=1.
REQ-031 Operation and md_op SHALL be purely combinational and independent of reset.

Verification
REQ-032 ALUOp=10, Funct7=0100000, Funct3=000 -> Operation=0110, md_op=0; ALUOp=11, Funct7=0100000, Funct3=000 -> Operation=0010.
REQ-033 XLEN=32, MUL SrcA=7, SrcB=0xFFFFFFFD, out_ready=1 -> out_valid exactly after 32 edges, md_result=0xFFFFFFEB; MULH same -> 0xFFFFFFFF.
REQ-034 DIV SrcA=0x80000000, SrcB=0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid and md_result held, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-036 reset=1 at iteration 10 of DIV -> next cycle busy=0, out_valid=0, md_result=0; subsequent DIVU 20/3 -> 6.
REQ-037 Changing SrcA/SrcB/Funct3 during EXEC -> result matches captured operands.
